// File: rtl/shift_register_ctrl.sv
// Load/shift sequencer: accepts a parallel word over valid/ready and serialises it onto the chain.
// Define SHIFT_REGISTER_CTRL_PARITY_EN to append an even-parity bit to every frame.
module shift_register_ctrl #(
  parameter int WIDTH     = 4,
  parameter int GAP       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  input  logic [WIDTH-1:0]             load_data,
  output logic                         load_ready,
  output logic                         ser_out,
  output logic                         shift_en,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         frame_start,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int unsigned UW = WIDTH;
`ifdef SHIFT_REGISTER_CTRL_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPS  = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_data;
  logic [3:0]        r_gap_cnt;
  logic              r_ser_out;
  logic              r_shift_en;
  logic [CW-1:0]     r_bit_cnt;
  logic              r_frame_start;
  logic              r_frame_done;
  logic              r_busy;

  logic              w_xfer;
  logic [CW-1:0]     w_nxt_cnt;
  int unsigned       w_nxt_idx;
  int unsigned       w_sel;
  logic              w_nxt_bit;
  logic              w_first_bit;

  assign load_ready  = (r_state == IDLE) && !rst;
  assign w_xfer      = load_valid && load_ready;
  assign ser_out     = r_ser_out;
  assign shift_en    = r_shift_en;
  assign bit_cnt     = r_bit_cnt;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign busy        = r_busy;

  // Output bits are registered, so the bit for the next cycle is selected from the captured word here.
  always_comb begin
    w_nxt_cnt   = r_bit_cnt + CW'(1);
    w_nxt_idx   = 32'(w_nxt_cnt);
    w_sel       = (MSB_FIRST != 0) ? (UW - 1 - w_nxt_idx) : w_nxt_idx;
    w_first_bit = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
    w_nxt_bit   = 1'b0;
    for (int unsigned i = 0; i < UW; i++) begin
      if (i == w_sel) w_nxt_bit = r_data[i];
    end
`ifdef SHIFT_REGISTER_CTRL_PARITY_EN
    if (w_nxt_idx == UW) w_nxt_bit = ^r_data;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_data        <= '0;
      r_gap_cnt     <= '0;
      r_ser_out     <= 1'b0;
      r_shift_en    <= 1'b0;
      r_bit_cnt     <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_state       <= SHIFT;
            r_data        <= load_data;
            r_ser_out     <= w_first_bit;
            r_shift_en    <= 1'b1;
            r_bit_cnt     <= '0;
            r_frame_start <= 1'b1;
            r_frame_done  <= (N == 1);
            r_busy        <= 1'b1;
          end
        end
        SHIFT: begin
          if (r_bit_cnt == CW'(N - 1)) begin
            r_ser_out    <= 1'b0;
            r_shift_en   <= 1'b0;
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
            if (GAP > 0) begin
              r_state   <= GAPS;
              r_gap_cnt <= 4'(GAP - 1);
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_ser_out    <= w_nxt_bit;
            r_bit_cnt    <= w_nxt_cnt;
            r_frame_done <= (w_nxt_cnt == CW'(N - 1));
          end
        end
        GAPS: begin
          if (r_gap_cnt == 4'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
